// File: rtl/dm_data_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
// Default geometry: 4 words/line, 16 sets, 32-bit byte addresses.
package cache_pkg;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_SETS   = 16;
  localparam int DEF_ADDR_W     = 32;

  localparam int OFFSET_W  = $clog2(DEF_LINE_WORDS);
  localparam int INDEX_W   = $clog2(DEF_NUM_SETS);
  localparam int TAG_W     = DEF_ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINE_BITS = 32 * DEF_LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_e;

  // Generic bit-field extract; callers cast the result down to the field width.
  function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int width);
    return (a >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_offset(input logic [63:0] a, input int offset_w);
    return addr_field(a, 2, offset_w);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] a, input int offset_w, input int index_w);
    return addr_field(a, offset_w + 2, index_w);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int offset_w, input int index_w,
                                           input int tag_w);
    return addr_field(a, offset_w + index_w + 2, tag_w);
  endfunction

endpackage

// File: rtl/dm_data_cache_line_array.sv
// Tag/valid/dirty/data storage for the cache: combinational read by index,
// word write and whole-line fill on posedge, async clear of valid/dirty only.
module cache_line_array #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 16,
  parameter int TAG_W      = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_SETS)-1:0] index_i,
  output logic [TAG_W-1:0]            tag_o,
  output logic                        valid_o,
  output logic                        dirty_o,
  output logic [32*LINE_WORDS-1:0]    line_o,
  input  logic                        wr_en_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_offset_i,
  input  logic [31:0]                 wr_word_i,
  input  logic                        fill_en_i,
  input  logic [TAG_W-1:0]            fill_tag_i,
  input  logic [32*LINE_WORDS-1:0]    fill_line_i
);

  localparam int LINE_W = 32 * LINE_WORDS;

  logic [TAG_W-1:0]    tag_q   [NUM_SETS];
  logic [LINE_W-1:0]   data_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Payload arrays are deliberately left out of reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      data_q[index_i] <= fill_line_i;
      tag_q[index_i]  <= fill_tag_i;
    end else if (wr_en_i) begin
      data_q[index_i][32*wr_offset_i +: 32] <= wr_word_i;
    end
  end

endmodule

// File: rtl/dm_data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// CPU responder handshake on one side, line-wide req/ack backing-memory port on the other.
module dm_data_cache
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_input_valid,
  input  logic                     mem_rw,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [31:0]              din,
  output logic                     is_ready,
  output logic                     is_output_valid,
  output logic                     is_hit,
  output logic [31:0]              dout,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [32*LINE_WORDS-1:0] mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                     mem_ack,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  // state     | meaning
  // IDLE      | accepting requests; hits complete combinationally
  // WRITEBACK | dirty victim line being written to backing memory
  // FILL      | requested line being fetched from backing memory

  localparam int OFS_W    = $clog2(LINE_WORDS);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_BITS = ADDR_W - IDX_W - OFS_W - 2;
  localparam int LINE_W   = 32 * LINE_WORDS;

  cache_state_e state_q, state_d;
  logic [31:0]  hit_q, hit_d, miss_q, miss_d;

  logic [OFS_W-1:0]    req_offset;
  logic [IDX_W-1:0]    req_index;
  logic [TAG_BITS-1:0] req_tag;
  logic [TAG_BITS-1:0] line_tag;
  logic                line_valid, line_dirty;
  logic [LINE_W-1:0]   line_data;
  logic                tag_match;
  logic                wr_en, fill_en, cnt_hit, cnt_miss;

  assign req_offset = OFS_W'(addr_offset(64'(addr), OFS_W));
  assign req_index  = IDX_W'(addr_index(64'(addr), OFS_W, IDX_W));
  assign req_tag    = TAG_BITS'(addr_tag(64'(addr), OFS_W, IDX_W, TAG_BITS));

  cache_line_array #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_SETS  (NUM_SETS),
    .TAG_W     (TAG_BITS)
  ) u_lines (
    .clk        (clk),
    .reset      (reset),
    .index_i    (req_index),
    .tag_o      (line_tag),
    .valid_o    (line_valid),
    .dirty_o    (line_dirty),
    .line_o     (line_data),
    .wr_en_i    (wr_en),
    .wr_offset_i(req_offset),
    .wr_word_i  (din),
    .fill_en_i  (fill_en),
    .fill_tag_i (req_tag),
    .fill_line_i(mem_rdata)
  );

  assign tag_match = line_valid && (line_tag == req_tag);
  assign is_hit    = is_input_valid && tag_match;
  assign dout      = is_hit ? line_data[32*req_offset +: 32] : 32'd0;
  assign mem_wdata = line_data;
  assign mem_addr  = (state_q == WRITEBACK) ? {line_tag, req_index, {(OFS_W+2){1'b0}}}
                                            : {req_tag,  req_index, {(OFS_W+2){1'b0}}};
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (is_input_valid && !tag_match) begin
          state_d = (line_valid && line_dirty) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: if (mem_ack) state_d = FILL;
      FILL:      if (mem_ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    wr_en           = 1'b0;
    fill_en         = 1'b0;
    cnt_hit         = 1'b0;
    cnt_miss        = 1'b0;
    unique case (state_q)
      IDLE: begin
        is_ready        = 1'b1;
        is_output_valid = !(is_input_valid && !is_hit);
        wr_en           = is_hit && mem_rw;
        cnt_hit         = is_hit;
        cnt_miss        = is_input_valid && !is_hit;
      end
      WRITEBACK: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      FILL: begin
        mem_req = 1'b1;
        fill_en = mem_ack;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_d  = hit_q  + {31'd0, cnt_hit};
    miss_d = miss_q + {31'd0, cnt_miss};
  end

endmodule

// File: tb/tb_dm_data_cache.sv
// Self-checking bench for dm_data_cache: directed scenarios plus a short random mix,
// with a load-data scoreboard and a behavioural backing memory.
module tb_dm_data_cache;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic         mem_rw;
  logic [31:0]  addr;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic         is_hit;
  logic [31:0]  dout;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  dm_data_cache dut (
    .clk            (clk),
    .reset          (reset),
    .is_input_valid (is_input_valid),
    .mem_rw         (mem_rw),
    .addr           (addr),
    .din            (din),
    .is_ready       (is_ready),
    .is_output_valid(is_output_valid),
    .is_hit         (is_hit),
    .dout           (dout),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_txn_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] bmem [1024];
  logic [31:0] gold [1024];
  logic [31:0] exp_q [$];
  mem_txn_t    txn_q [$];
  int          ack_delay = 0;
  logic        tb_valid [16];
  logic        tb_dirty [16];
  logic [23:0] tb_tag   [16];
  logic [31:0] exp_hits = 0;
  logic [31:0] exp_misses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory: acks ack_delay cycles after seeing mem_req, logs every transfer.
  initial begin
    int wait_cnt;
    mem_txn_t t;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!reset || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt < ack_delay) begin
        wait_cnt++;
      end else begin
        t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
        txn_q.push_back(t);
        for (int w = 0; w < 4; w++) begin
          if (mem_we) bmem[int'(mem_addr[11:2]) + w] = mem_wdata[w*32 +: 32];
          else        mem_rdata[w*32 +: 32] = bmem[int'(mem_addr[11:2]) + w];
        end
        mem_ack  = 1'b1;
        wait_cnt = 0;
      end
    end
  end

  task automatic do_access(input string tag, input logic rw, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
    int           idx, n_exp, stall_bad, addr_chg;
    logic [23:0]  t;
    logic         pred, vdirty, prev_ok, prev_we;
    logic [31:0]  vaddr, prev_addr, exp_d;
    logic [127:0] vline;
    idx    = int'(a[7:4]);
    t      = a[31:8];
    pred   = tb_valid[idx] && (tb_tag[idx] == t);
    vdirty = tb_valid[idx] && tb_dirty[idx] && !pred;
    vaddr  = {tb_tag[idx], a[7:4], 4'h0};
    for (int w = 0; w < 4; w++) vline[w*32 +: 32] = gold[int'(vaddr[11:2]) + w];
    n_exp  = pred ? 0 : (vdirty ? 2 : 1);
    txn_q.delete();

    @(negedge clk);
    is_input_valid = 1'b1; mem_rw = rw; addr = a; din = d;
    if (rw) gold[a[11:2]] = d;
    else    exp_q.push_back(gold[a[11:2]]);
    #1;
    check_val({tag, "/hit_first"}, is_hit, pred);

    lat = 0; stall_bad = 0; addr_chg = 0; prev_ok = 1'b0; prev_we = 1'b0; prev_addr = '0;
    while (!is_output_valid && lat < 200) begin
      @(negedge clk); #1;
      lat++;
      if (!is_output_valid) begin
        if (is_ready) stall_bad++;
        if (mem_req) begin
          if (prev_ok && prev_we == mem_we && prev_addr != mem_addr) addr_chg++;
          prev_ok = 1'b1; prev_we = mem_we; prev_addr = mem_addr;
        end
      end
    end
    check_val({tag, "/done"}, is_output_valid, 1'b1);
    check_val({tag, "/hit_final"}, is_hit, 1'b1);
    if (!rw) begin
      exp_d = exp_q.pop_front();
      check_val({tag, "/dout"}, dout, exp_d);
    end
    check_val({tag, "/stall_ready"}, stall_bad, 0);
    check_val({tag, "/addr_stable"}, addr_chg, 0);
    check_val({tag, "/txn_count"}, txn_q.size(), n_exp);
    if (txn_q.size() == n_exp && n_exp > 0) begin
      check_val({tag, "/fill_we"}, txn_q[n_exp-1].we, 1'b0);
      check_val({tag, "/fill_addr"}, txn_q[n_exp-1].addr, {a[31:4], 4'h0});
      if (n_exp == 2) begin
        check_val({tag, "/wb_we"}, txn_q[0].we, 1'b1);
        check_val({tag, "/wb_addr"}, txn_q[0].addr, vaddr);
        check_val({tag, "/wb_data"}, txn_q[0].wdata, vline);
      end
    end

    @(posedge clk); #1;
    is_input_valid = 1'b0;
    tb_dirty[idx] = rw ? 1'b1 : (pred ? tb_dirty[idx] : 1'b0);
    tb_valid[idx] = 1'b1;
    tb_tag[idx]   = t;
    exp_hits++;
    if (!pred) exp_misses++;
    check_val({tag, "/hit_count"}, hit_count, exp_hits);
    check_val({tag, "/miss_count"}, miss_count, exp_misses);
  endtask

  initial begin
    int lat;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) bmem[i] = 32'hA000_0000 + i;
    bmem[32'h40] = 32'd1; bmem[32'h41] = 32'd2; bmem[32'h42] = 32'd3; bmem[32'h43] = 32'd4;
    for (int i = 0; i < 1024; i++) gold[i] = bmem[i];
    for (int i = 0; i < 16; i++) begin tb_valid[i] = 1'b0; tb_dirty[i] = 1'b0; tb_tag[i] = '0; end
    reset = 1'b0; is_input_valid = 1'b0; mem_rw = 1'b0; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    check_val("rst/mem_req", mem_req, 1'b0);
    check_val("rst/hits", hit_count, 0);
    check_val("rst/misses", miss_count, 0);
    reset = 1'b1;
    @(negedge clk); #1;
    check_val("idle/ready", is_ready, 1'b1);
    check_val("idle/out_valid", is_output_valid, 1'b1);
    check_val("idle/is_hit", is_hit, 1'b0);
    check_val("idle/dout", dout, 0);

    do_access("t1_load100", 1'b0, 32'h100, 32'h0, lat);
    check_val("t1/lat", lat, 2);
    do_access("t2_load104", 1'b0, 32'h104, 32'h0, lat);
    check_val("t2/lat", lat, 0);
    do_access("t3_store108", 1'b1, 32'h108, 32'hDEAD, lat);
    check_val("t3/store_lat", lat, 0);
    do_access("t3_load108", 1'b0, 32'h108, 32'h0, lat);
    do_access("t4_load500", 1'b0, 32'h500, 32'h0, lat);
    check_val("t4/lat", lat, 3);
    check_val("t4/bmem_dead", bmem[32'h42], 32'hDEAD);

    ack_delay = 10;
    do_access("t5_slow_fill", 1'b0, 32'h904, 32'h0, lat);
    check_val("t5/lat", lat, 12);

    ack_delay = 0;
    do_access("t6_dirty", 1'b1, 32'h908, 32'h1234_5678, lat);
    ack_delay = 5;
    @(negedge clk);
    is_input_valid = 1'b1; mem_rw = 1'b0; addr = 32'h100;
    @(negedge clk); #1;
    check_val("t6/in_wb_req", mem_req, 1'b1);
    check_val("t6/in_wb_we", mem_we, 1'b1);
    check_val("t6/in_wb_addr", mem_addr, 32'h900);
    reset = 1'b0;
    #1;
    check_val("t6/rst_mem_req", mem_req, 1'b0);
    check_val("t6/rst_misses", miss_count, 0);
    is_input_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    for (int i = 0; i < 16; i++) begin tb_valid[i] = 1'b0; tb_dirty[i] = 1'b0; end
    gold[32'h242] = bmem[32'h242];
    exp_hits = 0; exp_misses = 0;
    do_access("t6_reload100", 1'b0, 32'h100, 32'h0, lat);

    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      ack_delay = $urandom_range(0, 3);
      do_access("rnd", 1'($urandom_range(0, 1)), a, $urandom, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
